// File: rtl/freecpu_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding, requester indices
// and a small one-hot helper.
package freecpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } arb_state_t;

  localparam int REQ_VGA  = 0;
  localparam int REQ_CORE = 1;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// Winner selection for the two RAM requesters. Round-robin on ties when
// ARB_ROUND_ROBIN_EN is defined, fixed VGA priority otherwise.
module arb_pick
  import freecpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = req;
    if (req == 2'b11) winner = req_onehot(~last_owner);
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = req;
    if (req[REQ_VGA]) winner = req_onehot(1'b0);
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter (VGA fetcher, core0) in front of a single RAM
// controller. Tie-break policy selected by ARB_ROUND_ROBIN_EN.
//
// state   | meaning
// IDLE    | waiting for a request; winner operands latched on exit
// GRANT   | one-cycle gnt pulse to the owner
// ISSUE   | one-cycle read/write command pulse, timeout counter cleared
// WAIT    | waiting for mem_event or timeout; done/err registered on exit
module ram_arbiter
  import freecpu_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_req_read,
  output logic                  mem_req_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_event
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state, state_nxt;
  logic [1:0]        winner;
  logic              owner;
  logic              own_we;
  logic              last_owner;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_hit;

  arb_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (mem_event || timeout_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt           = '0;
    mem_req_read  = 1'b0;
    mem_req_write = 1'b0;
    case (state)
      S_GRANT: gnt = req_onehot(owner);
      S_ISSUE: begin
        mem_req_read  = ~own_we;
        mem_req_write = own_we;
      end
      default: ;
    endcase
  end

  // Operands are latched once in IDLE so they stay stable through WAIT even
  // if the requester drops req or changes addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      own_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_owner <= 1'b1;
      cnt        <= '0;
      done       <= '0;
      err        <= '0;
      rdata      <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: if (|req) begin
          owner     <= winner[REQ_CORE];
          own_we    <= winner[REQ_CORE] ? we[REQ_CORE] : we[REQ_VGA];
          mem_addr  <= winner[REQ_CORE] ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
          mem_wdata <= winner[REQ_CORE] ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_event) begin
            done       <= req_onehot(owner);
            last_owner <= owner;
            if (!own_we) rdata <= mem_rdata;
          end else if (timeout_hit) begin
            done       <= req_onehot(owner);
            err        <= req_onehot(owner);
            last_owner <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single transactions plus a
// hand-written reset-in-WAIT sequence. TIMEOUT is shrunk to 8.
module tb_ram_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt, done, err;
  logic [DW-1:0]   rdata;
  logic            mem_req_read, mem_req_write;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_event;

  int n_chk = 0;
  int n_fail = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_event(mem_event)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          hold;
    int            ev;
    logic [DW-1:0] mrd;
    logic          owner;
    logic          is_wr;
    logic          err;
    int            exp_k;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  task automatic run_txn(input vec_t v, input int n);
    int  k;
    bit  seen;
    req   = v.req;
    we    = v.we;
    addr  = {v.addr1, v.addr0};
    wdata = {v.wdata1, v.wdata0};
    tick();
    if (!v.hold) req = 2'b00;
    chk($sformatf("v%0d_gnt", n), gnt, oh(v.owner));
    tick();
    chk($sformatf("v%0d_gnt_clr", n), gnt, 0);
    chk($sformatf("v%0d_rd_pulse", n), mem_req_read, !v.is_wr);
    chk($sformatf("v%0d_wr_pulse", n), mem_req_write, v.is_wr);
    chk($sformatf("v%0d_mem_addr", n), mem_addr, v.exp_addr);
    chk($sformatf("v%0d_mem_wdata", n), mem_wdata, v.exp_wdata);
    tick();
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      mem_event = (k == v.ev);
      mem_rdata = v.mrd;
      chk($sformatf("v%0d_wait_cmd", n), {mem_req_read, mem_req_write, done}, 0);
      chk($sformatf("v%0d_wait_addr", n), {mem_addr, mem_wdata}, {v.exp_addr, v.exp_wdata});
      tick();
      mem_event = 1'b0;
      if (done != 2'b00) seen = 1;
      else k++;
    end
    chk($sformatf("v%0d_done_seen", n), seen, 1);
    chk($sformatf("v%0d_latency", n), k, v.exp_k);
    chk($sformatf("v%0d_done", n), done, oh(v.owner));
    chk($sformatf("v%0d_err", n), err, v.err ? oh(v.owner) : 2'b00);
    chk($sformatf("v%0d_rdata", n), rdata, v.exp_rdata);
    if (!v.hold) begin
      tick();
      chk($sformatf("v%0d_done_pulse", n), {done, err}, 0);
      chk($sformatf("v%0d_rdata_hold", n), rdata, v.exp_rdata);
    end
  endtask

  initial begin
    logic [1:0] own1;
    logic [AW-1:0] a1;
    logic [DW-1:0] w1;
`ifdef ARB_ROUND_ROBIN_EN
    own1 = 1'b1; a1 = 22'h00222; w1 = 16'h2222;
`else
    own1 = 1'b0; a1 = 22'h00111; w1 = 16'h1111;
`endif
    //          req    we     addr0      addr1      wd0       wd1       hold ev  mrd       own      wr   err  k  exp_addr   exp_wd    exp_rd
    vecs[0] = '{2'b11, 2'b00, 22'h00111, 22'h00222, 16'h1111, 16'h2222, 1'b1, 0, 16'hA001, 1'b0,    1'b0, 1'b0, 0, 22'h00111, 16'h1111, 16'hA001};
    vecs[1] = '{2'b11, 2'b00, 22'h00111, 22'h00222, 16'h1111, 16'h2222, 1'b0, 0, 16'hA002, own1[0], 1'b0, 1'b0, 0, a1,        w1,       16'hA002};
    vecs[2] = '{2'b10, 2'b00, 22'h00000, 22'h00123, 16'h0000, 16'h0000, 1'b0, 2, 16'hBEEF, 1'b1,    1'b0, 1'b0, 2, 22'h00123, 16'h0000, 16'hBEEF};
    vecs[3] = '{2'b01, 2'b01, 22'h3ABCD, 22'h00000, 16'h55AA, 16'h0000, 1'b0, 1, 16'h1234, 1'b0,    1'b1, 1'b0, 1, 22'h3ABCD, 16'h55AA, 16'hBEEF};
    vecs[4] = '{2'b10, 2'b00, 22'h00000, 22'h2F0F0, 16'h0000, 16'h0000, 1'b0, 99, 16'hDEAD, 1'b1,   1'b0, 1'b1, 7, 22'h2F0F0, 16'h0000, 16'hBEEF};
    vecs[5] = '{2'b01, 2'b00, 22'h01234, 22'h00000, 16'h0000, 16'h0000, 1'b0, 7, 16'hC0DE, 1'b0,    1'b0, 1'b0, 7, 22'h01234, 16'h0000, 16'hC0DE};

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_event = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", {gnt, done, err, mem_req_read, mem_req_write}, 0);
    chk("reset_data", {rdata, mem_addr, mem_wdata}, 0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Reset while waiting on the RAM, then a stale completion arrives.
    req = 2'b01; we = 2'b00; addr = {22'h0, 22'h00155}; wdata = {16'h0, 16'h7777};
    tick();
    req = 2'b00;
    tick();
    tick();
    tick();
    chk("pre_rst_addr", mem_addr, 22'h00155);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_event = 1'b1;
    mem_rdata = 16'hFFFF;
    tick();
    mem_event = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("rst_abort_ctl", {gnt, done, err, mem_req_read, mem_req_write}, 0);
      chk("rst_abort_data", {rdata, mem_addr, mem_wdata}, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 22, main-memory word address width (bank, row and column).
REQ-002 Parameter DATA_W, default 16, data bus width, matching the RAM data bus.
REQ-003 Parameter TIMEOUT, default 1024, cycles to wait for mem_event before aborting.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  2  per-requester request; bit 0 is the VGA fetcher, bit 1 is core0.
REQ-007 we  in  2  per-requester write flag; 1 means write, 0 means read.
REQ-008 addr  in  2*ADDR_W  per-requester address; requester n occupies slice [n*ADDR_W +: ADDR_W].
REQ-009 wdata  in  2*DATA_W  per-requester write data, sliced the same way as addr.
REQ-010 gnt  out  2  one-cycle grant pulse; the request is consumed on this cycle.
REQ-011 done  out  2  one-cycle completion pulse to the owning requester.
REQ-012 err  out  2  one-cycle timeout flag, coincident with done.
REQ-013 rdata  out  DATA_W  read data; valid on the done cycle and held until the next done.
REQ-014 mem_req_read / mem_req_write  out  1 each  one-cycle command pulses to the RAM controller.
REQ-015 mem_addr  out  ADDR_W and mem_wdata  out  DATA_W  latched command operands.
REQ-016 mem_rdata  in  DATA_W and mem_event  in  1  RAM completion data and completion pulse.

Function
REQ-017 The FSM SHALL have four states: IDLE, GRANT, ISSUE and WAIT.
REQ-018 In IDLE with req != 0, the arbiter SHALL select a winner, latch its we, addr and wdata into owner registers, and move to GRANT.
REQ-019 In GRANT, gnt[owner] SHALL be high for exactly one cycle, and the FSM SHALL move to ISSUE.
REQ-020 In ISSUE, exactly one of mem_req_read or mem_req_write SHALL pulse for one cycle according to the latched we, and the FSM SHALL move to WAIT; the timeout counter SHALL clear.
REQ-021 In WAIT, on mem_event the arbiter SHALL capture mem_rdata into rdata (reads only), pulse done[owner], and return to IDLE.
REQ-022 In WAIT, the timeout counter SHALL increment each cycle; at TIMEOUT-1 without mem_event, done[owner] and err[owner] SHALL pulse together, rdata SHALL be unchanged, and the FSM SHALL return to IDLE.
REQ-023 mem_event SHALL win over timeout when both occur in the same cycle, so err stays low.
REQ-024 mem_event outside WAIT SHALL be ignored.
REQ-025 mem_addr and mem_wdata SHALL hold stable from ISSUE through WAIT.
REQ-026 Deasserting req after the winner is selected SHALL NOT cancel the transaction; req still high after done SHALL count as a new request.
REQ-027 Back-to-back transactions SHALL take at least 4 cycles each, from IDLE to the done pulse and back to IDLE.
REQ-028 At most one bit of gnt, done and err SHALL be set at any time.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE; gnt, done, err, mem_req_read and mem_req_write SHALL be 0; rdata, mem_addr, mem_wdata and the counter SHALL be 0; and last-owner SHALL be 1.
REQ-030 rst asserted mid-transaction SHALL abort it with no done pulse, and a late mem_event after reset SHALL be ignored.

Configuration
REQ-031 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester other than last-owner; last-owner updates at done.
REQ-032 Without ARB_ROUND_ROBIN_EN, requester 0 (VGA) SHALL always win simultaneous requests (fixed priority), and last-owner SHALL be unused.

Structure
REQ-033 The FSM state encodings and the requester indices (REQ_VGA=0, REQ_CORE=1) SHALL live in the shared package freecpu_pkg.
REQ-034 Winner selection SHALL be a sub-module, arb_pick (inputs: req and last-owner; output: a one-hot winner), selecting its behaviour under ARB_ROUND_ROBIN_EN.

Verification
REQ-035 Read, single requester: req=2'b10, we=0, addr1=0x00123, mem_event with mem_rdata=0xBEEF 3 cycles after mem_req_read -> gnt=2'b10, mem_addr=0x00123, done=2'b10, rdata=0xBEEF.
REQ-036 Simultaneous requests: req=2'b11 held for two transactions -> with the macro, owners are 0 then 1; without it, owners are 0 then 0.
REQ-037 Timeout: TIMEOUT=8 and no mem_event -> done[owner]=err[owner]=1 exactly 8 cycles after entering WAIT, with rdata unchanged.
REQ-038 Write: we=2'b01, wdata0=0x55AA -> mem_req_write pulses once, mem_wdata=0x55AA, done=2'b01, rdata unchanged.
REQ-039 Reset in WAIT, then mem_event -> FSM in IDLE, no done pulse, all outputs 0.
REQ-040 Race: mem_event arrives on the timeout cycle -> done=1, err=0, rdata=mem_rdata.
